// File: rtl/divider_timer_scheduler.sv
// Shared power-of-two interval timer with round-robin grant among NREQ requesters.
// Optional DIVOUT square-wave output is enabled by defining SCHED_DIVOUT_EN.
//
// Handshake: REQ is a level request and acts as valid. GNT is the ready/ownership
// response. An interval starts on any edge in IDLE where REQ is nonzero. It ends
// with a one-cycle DONE pulse to the owner, or silently on ABORT. REQ may drop
// while GNT is held without affecting the interval.
module divider_timer_scheduler #(
  parameter int NREQ   = 4,
  parameter int EXPW   = 5,
  parameter int MAXEXP = 20
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ*EXPW-1:0] EXP,
  input  logic                 ABORT,
  output logic [NREQ-1:0]      GNT,
  output logic [NREQ-1:0]      DONE,
  output logic                 BUSY,
  output logic [MAXEXP-1:0]    CNT
`ifdef SCHED_DIVOUT_EN
  ,
  output logic                 DIVOUT
`endif
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic [MAXEXP-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]       last_q, last_d;
  logic [IW-1:0]       owner_q, owner_d;
`ifdef SCHED_DIVOUT_EN
  logic                divout_q, divout_d;
`endif

  // Round-robin search starting just after the last served index.
  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic [EXPW-1:0]   win_exp;
  logic [MAXEXP-1:0] win_load;
  logic [MAXEXP-1:0] all_ones;
  int                idx;
  int                exp_eff;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = int'(last_q) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && REQ[idx]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end

  // Exponents above MAXEXP clamp to the full counter width.
  always_comb begin
    all_ones = '1;
    win_exp  = EXP[int'(win_idx)*EXPW +: EXPW];
    exp_eff  = (int'(win_exp) > MAXEXP) ? MAXEXP : int'(win_exp);
    win_load = all_ones >> (MAXEXP - exp_eff);
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = owner_q;
`ifdef SCHED_DIVOUT_EN
    divout_d = divout_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d          = RUN;
          gnt_d            = '0;
          gnt_d[win_idx]   = 1'b1;
          cnt_d            = win_load;
          owner_d          = win_idx;
        end
      end
      RUN: begin
        if (ABORT) begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
          last_d  = owner_q;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
          gnt_d   = '0;
          done_d  = gnt_q;
          last_d  = owner_q;
`ifdef SCHED_DIVOUT_EN
          divout_d = ~divout_q;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      owner_q <= '0;
`ifdef SCHED_DIVOUT_EN
      divout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
`ifdef SCHED_DIVOUT_EN
      divout_q <= divout_d;
`endif
    end
  end

  // BUSY is the direct debug view of the state register.
  assign GNT  = gnt_q;
  assign DONE = done_q;
  assign BUSY = (state_q == RUN);
  assign CNT  = cnt_q;
`ifdef SCHED_DIVOUT_EN
  assign DIVOUT = divout_q;
`endif

endmodule

// File: tb/tb_divider_timer_scheduler.sv
// Self-checking bench for divider_timer_scheduler: expected {index, grant length}
// entries are queued as intervals are requested and popped on each DONE pulse.
module tb_divider_timer_scheduler;

  localparam int NREQ   = 4;
  localparam int EXPW   = 5;
  localparam int MAXEXP = 20;

  logic                 CLK = 1'b0;
  logic                 RESETN = 1'b0;
  logic [NREQ-1:0]      REQ = '0;
  logic [NREQ*EXPW-1:0] EXP = '0;
  logic                 ABORT = 1'b0;
  logic [NREQ-1:0]      GNT;
  logic [NREQ-1:0]      DONE;
  logic                 BUSY;
  logic [MAXEXP-1:0]    CNT;
`ifdef SCHED_DIVOUT_EN
  logic                 DIVOUT;
`endif

  divider_timer_scheduler #(.NREQ(NREQ), .EXPW(EXPW), .MAXEXP(MAXEXP)) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .REQ    (REQ),
    .EXP    (EXP),
    .ABORT  (ABORT),
    .GNT    (GNT),
    .DONE   (DONE),
    .BUSY   (BUSY),
    .CNT    (CNT)
`ifdef SCHED_DIVOUT_EN
    ,
    .DIVOUT (DIVOUT)
`endif
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  int done_cnt = 0;
  int done_cyc[$];
  logic [NREQ-1:0] prev_gnt = '0;
  int gnt_len = 0;
  logic exp_div = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return 15;
  endfunction

  always @(negedge CLK) begin
    logic [3:0]  di;
    logic [11:0] ll;
    logic [15:0] e;
    if (!RESETN) begin
      prev_gnt = '0;
      gnt_len  = 0;
      exp_div  = 1'b0;
    end else begin
      check_eq("excl_done_gnt", 32'(DONE & GNT), 0);
      check_eq("gnt_onehot", 32'($countones(GNT) > 1), 0);
      check_eq("done_onehot", 32'($countones(DONE) > 1), 0);
      check_eq("busy_vs_gnt", 32'(BUSY), 32'(|GNT));
      if (GNT != '0) begin
        if (GNT != prev_gnt) gnt_len = 1;
        else gnt_len++;
      end
      if (DONE != '0) begin
        done_cnt++;
        done_cyc.push_back(cyc);
        exp_div = ~exp_div;
        if (exp_q.size() == 0) begin
          check_eq("done_unexpected", 32'(DONE), 0);
        end else begin
          e  = exp_q.pop_front();
          di = 4'(onehot_idx(DONE));
          ll = 12'(gnt_len);
          check_eq("done_idx_len", 32'({di, ll}), 32'(e));
        end
      end
`ifdef SCHED_DIVOUT_EN
      check_eq("divout", 32'(DIVOUT), 32'(exp_div));
`endif
      prev_gnt = GNT;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_exp(input int i, input int v);
    EXP[i*EXPW +: EXPW] = EXPW'(v);
  endtask

  task automatic push_exp(input int i, input int len);
    exp_q.push_back({4'(i), 12'(len)});
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check_eq("drain_empty", 32'(exp_q.size()), 0);
    exp_q.delete();
    repeat (2) tick();
  endtask

  task automatic do_reset();
    RESETN = 1'b0;
    repeat (2) tick();
    RESETN = 1'b1;
    tick();
  endtask

  task automatic wait_dones(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check_eq("done_count", 32'(done_cnt), 32'(target));
  endtask

  task automatic check_spacing(input int base, input int cnt, input int gap);
    if (done_cyc.size() >= base + cnt) begin
      for (int i = 1; i < cnt; i++)
        check_eq("done_spacing", 32'(done_cyc[base+i] - done_cyc[base+i-1]), 32'(gap));
    end else begin
      check_eq("spacing_samples", 32'(done_cyc.size()), 32'(base + cnt));
    end
  endtask

  // stimulus
  initial begin
    int base;
    int target;
    logic div_save;

    // reset state
    @(negedge CLK);
    #1;
    check_eq("rst_gnt", 32'(GNT), 0);
    check_eq("rst_done", 32'(DONE), 0);
    check_eq("rst_busy", 32'(BUSY), 0);
    check_eq("rst_cnt", 32'(CNT), 0);
    tick();
    RESETN = 1'b1;
    tick();

    // reset mid-RUN, then regrant
    set_exp(0, 5);
    REQ = 4'b0001;
    tick();
    check_eq("s1_gnt", 32'(GNT), 32'h1);
    repeat (9) tick();
    check_eq("s1_run_gnt", 32'(GNT), 32'h1);
    #2;
    RESETN = 1'b0;
    #1;
    check_eq("s1_arst_gnt", 32'(GNT), 0);
    check_eq("s1_arst_done", 32'(DONE), 0);
    check_eq("s1_arst_busy", 32'(BUSY), 0);
    check_eq("s1_arst_cnt", 32'(CNT), 0);
    tick();
    RESETN = 1'b1;
    tick();
    check_eq("s1_regrant_gnt", 32'(GNT), 32'h1);
    check_eq("s1_regrant_cnt", 32'(CNT), 31);
    push_exp(0, 32);
    REQ = '0;
    drain(100);

    // single interval; ABORT in IDLE must not block the grant
    set_exp(1, 3);
    REQ   = 4'b0010;
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    REQ   = '0;
    check_eq("s2_gnt", 32'(GNT), 32'h2);
    check_eq("s2_cnt", 32'(CNT), 7);
    check_eq("s2_busy", 32'(BUSY), 1);
    push_exp(1, 8);
    drain(50);

    // round robin from reset priority
    do_reset();
    for (int i = 0; i < NREQ; i++) set_exp(i, 1);
    push_exp(0, 2);
    push_exp(1, 2);
    push_exp(2, 2);
    push_exp(3, 2);
    push_exp(0, 2);
    base   = done_cyc.size();
    target = done_cnt + 5;
    REQ = 4'b1111;
    begin
      int n = 0;
      while (done_cnt < target && n < 100) begin
        @(negedge CLK);
        #1;
        n++;
      end
    end
    REQ = '0;
    check_eq("s3_done_count", 32'(done_cnt), 32'(target));
    check_spacing(base, 5, 3);
    drain(20);

    // clamp to MAXEXP, cut short by ABORT
    set_exp(2, 31);
    REQ = 4'b0100;
    tick();
    REQ = '0;
    check_eq("s4_gnt", 32'(GNT), 32'h4);
    check_eq("s4_clamp_cnt", 32'(CNT), 32'hFFFFF);
    tick();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    check_eq("s4_abort_gnt", 32'(GNT), 0);
    check_eq("s4_abort_cnt", 32'(CNT), 0);
    check_eq("s4_abort_busy", 32'(BUSY), 0);
    check_eq("s4_abort_done", 32'(DONE), 0);

    // zero exponent: one-cycle grant
    set_exp(3, 0);
    REQ = 4'b1000;
    tick();
    REQ = '0;
    check_eq("s4_zero_gnt", 32'(GNT), 32'h8);
    check_eq("s4_zero_cnt", 32'(CNT), 0);
    push_exp(3, 1);
    drain(20);

    // abort on the 6th RUN cycle, then round robin moves to index 1
    set_exp(0, 4);
    set_exp(1, 1);
    REQ = 4'b0011;
    tick();
    check_eq("s5_gnt0", 32'(GNT), 32'h1);
    repeat (5) tick();
    check_eq("s5_cnt_before_abort", 32'(CNT), 10);
    ABORT = 1'b1;
    push_exp(1, 2);
    tick();
    ABORT = 1'b0;
    check_eq("s5_abort_gnt", 32'(GNT), 0);
    check_eq("s5_abort_cnt", 32'(CNT), 0);
    tick();
    check_eq("s5_next_gnt", 32'(GNT), 32'h2);
    REQ = '0;
    drain(20);

`ifdef SCHED_DIVOUT_EN
    // DIVOUT toggles on each DONE, not on ABORT
    do_reset();
    check_eq("s6_divout_rst", 32'(DIVOUT), 0);
    set_exp(0, 2);
    push_exp(0, 4);
    push_exp(0, 4);
    push_exp(0, 4);
    base   = done_cyc.size();
    target = done_cnt + 3;
    REQ = 4'b0001;
    wait_dones(target, 100);
    check_spacing(base, 3, 5);
    div_save = DIVOUT;
    tick();
    check_eq("s6_regrant", 32'(GNT), 32'h1);
    ABORT = 1'b1;
    REQ   = '0;
    tick();
    ABORT = 1'b0;
    check_eq("s6_abort_gnt", 32'(GNT), 0);
    repeat (3) tick();
    check_eq("s6_divout_hold", 32'(DIVOUT), 32'(div_save));
    drain(20);
`endif

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/divider_timer_scheduler.md
Name: divider_timer_scheduler

Overview:
- Synchronous power-of-two interval timer, shared round-robin among NREQ requesters.
- Replaces per-user ripple divider chains with one counter: a requester asks for a 2^EXP-cycle interval, waits for a grant, and receives a one-cycle DONE pulse when the interval expires.
- Sits between the system clock domain and the slow-timing consumers (blinkers, debouncers, display refresh).
- Everything is clocked on CLK; no derived clocks.

Parameters:
- NREQ, 4, number of requesters (2..8).
- EXPW, 5, width of each exponent field.
- MAXEXP, 20, largest supported exponent; counter width = MAXEXP bits.

Ports:
- CLK  input  1  system clock, rising edge.
- RESETN  input  1  asynchronous active-low reset.
- REQ  input  NREQ  level request per requester.
- EXP  input  NREQ*EXPW  exponent per requester; field i = EXP[i*EXPW +: EXPW].
- ABORT  input  1  cancel the current interval.
- GNT  output  NREQ  one-hot owner of the timer; all zero when idle.
- DONE  output  NREQ  one-cycle expiry pulse to the owner.
- BUSY  output  1  high while in RUN.
- CNT  output  MAXEXP  current remaining count (debug).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: GNT=0, DONE=0, BUSY=0, CNT=0, state=IDLE, last-granted pointer=NREQ-1, so index 0 has top priority after reset.
- FSM states: IDLE, RUN.
- IDLE, REQ==0: hold; DONE returns to 0.
- IDLE, REQ!=0 at edge k: winner = first set REQ bit searching upward (with wrap) from last+1.
  - state<=RUN, GNT<=onehot(winner), BUSY<=1.
  - CNT<=2^E-1, where E = min(EXP[winner], MAXEXP); EXP values above MAXEXP are clamped.
  - EXP is sampled only at grant; later EXP changes are ignored until the next grant.
- RUN, CNT!=0: CNT<=CNT-1.
- RUN, CNT==0: state<=IDLE, GNT<=0, BUSY<=0, DONE[winner]<=1 for exactly one cycle, last<=winner.
  - GNT is therefore high for exactly 2^E cycles.
  - E=0 gives a one-cycle GNT.
- Back-to-back: the DONE cycle is an IDLE cycle and arbitrates normally. The next GNT rises at the edge ending the DONE cycle, leaving a 1-cycle GNT gap.
- REQ deassertion during RUN is ignored; the interval completes.
- A requester still holding REQ in its DONE cycle is eligible, but at lowest round-robin priority.
- ABORT:
  - Sampled only in RUN. At that edge: state<=IDLE, GNT<=0, BUSY<=0, CNT<=0, no DONE; last<=aborted index.
  - ABORT has priority over CNT==0 on the same edge.
  - ABORT in IDLE has no effect and does not block arbitration.
- Reset mid-RUN: all outputs return to reset values immediately (asynchronous); no DONE is issued.
- DONE and GNT are never high for the same index in the same cycle. At most one DONE bit is high at a time.

Optional Feature:
- Macro SCHED_DIVOUT_EN.
- Defined: adds output port DIVOUT (1 bit, reset 0). DIVOUT toggles on every edge that issues a DONE, giving a square wave at half the completion rate. With a single continuously requesting user at exponent E, DIVOUT period = 2*(2^E+1) cycles.
- ABORT does not toggle DIVOUT.
- Undefined: DIVOUT port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset: RESETN=0 mid-RUN (REQ=4'b0001, EXP0=5, after 10 cycles) -> GNT=0, DONE=0, BUSY=0, CNT=0 immediately. After release, REQ0 regranted with CNT=31.
- Single interval: REQ=4'b0010, EXP1=3 -> GNT=4'b0010 for exactly 8 cycles, then DONE=4'b0010 for 1 cycle, BUSY falls with GNT.
- Round-robin: REQ=4'b1111 held, all EXP=1 -> grants in order 0,1,2,3,0 at 3-cycle spacing (2 GNT cycles + 1 gap), with DONE pulses in the same order.
- Clamp and zero: EXP2=31 -> CNT loads 20'hFFFFF. EXP3=0 -> GNT high 1 cycle, then DONE.
- Abort: REQ=4'b0001, EXP0=4, ABORT pulsed on the 6th RUN cycle -> GNT drops next edge, no DONE. With REQ=4'b0011, the next grant goes to index 1.
- SCHED_DIVOUT_EN: REQ0 held, EXP0=2 -> DIVOUT toggles every 5 cycles (period 10). Inject one ABORT -> that interval produces no toggle.
